scaled_image_mapper: RTL

- Parametrised full-screen image mapper. Scales an IMG_W x IMG_H palette-indexed ROM image onto the SCREEN_W x SCREEN_H VGA raster.
- Uses incremental (DDA) row/column stepping instead of multiply/divide address math.
- Drives an external synchronous image ROM and an external palette, and applies a frame-stepped fade in/out.
- Sits between the VGA controller (DrawX/DrawY/blank) and the colour-mux used by the background/state screens.

---
 rtl/scaled_image_mapper.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/scaled_image_mapper.sv
// Scaled full-screen image mapper: steps a small palette-indexed ROM image
// across the VGA raster with DDA accumulators, looks the colour up through an
// external palette and applies a frame-stepped fade before registering RGB.
module scaled_image_mapper #(
  parameter int IMG_W           = 105,
  parameter int IMG_H           = 117,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int ADDR_W          = 15,
  parameter int IDX_W           = 4,
  parameter int COLOR_W         = 4,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pal_index,
  input  logic [COLOR_W-1:0] pal_red,
  input  logic [COLOR_W-1:0] pal_green,
  input  logic [COLOR_W-1:0] pal_blue,
  input  logic               fade_start,
  input  logic               fade_dir,
  output logic               fade_busy,
  output logic               fade_done,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  // Accumulators hold at most SCREEN + IMG - 1 < 2048 for a 10-bit raster.
  localparam int ACC_W = 12;
  localparam logic [ACC_W-1:0]  IMG_W_A    = ACC_W'(IMG_W);
  localparam logic [ACC_W-1:0]  IMG_H_A    = ACC_W'(IMG_H);
  localparam logic [ACC_W-1:0]  SCREEN_W_A = ACC_W'(SCREEN_W);
  localparam logic [ACC_W-1:0]  SCREEN_H_A = ACC_W'(SCREEN_H);
  localparam logic [ADDR_W-1:0] IMG_W_ADDR = ADDR_W'(IMG_W);
  localparam int CNT_W = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [CNT_W-1:0]   FPS_C = CNT_W'(FRAMES_PER_STEP);
  localparam logic [COLOR_W:0]   FULL  = {1'b1, {COLOR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, FADE_IN, FADE_OUT} fade_state_e;

  logic [9:0]        prev_x, prev_y;
  logic [ACC_W-1:0]  ex, ex_next, ex_sum;
  logic [ACC_W-1:0]  ey, ey_next, ey_sum;
  logic [ADDR_W-1:0] col, col_next;
  logic [ADDR_W-1:0] row_base, row_base_next;
  logic              blank_d1, blank_d2;
  logic              prev_zero, frame_tick;
  fade_state_e       state, state_next;
  logic [CNT_W-1:0]  frame_cnt, cnt_next, cnt_inc;
  logic [COLOR_W:0]  level, level_next, level_step, bound;
  logic              done_next;

  // (c * level) >> COLOR_W; the clamp only matters if level ever exceeded FULL.
  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [COLOR_W:0]   lvl);
    logic [COLOR_W:0] hi;
    hi = (COLOR_W+1)'(({{(COLOR_W+1){1'b0}}, c} * {{COLOR_W{1'b0}}, lvl}) >> COLOR_W);
    return hi[COLOR_W] ? {COLOR_W{1'b1}} : hi[COLOR_W-1:0];
  endfunction

  // Column DDA: restart at X=0, step only on X = prevX+1, otherwise hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    ex_sum   = ex + IMG_W_A;
    col_next = col;
    ex_next  = ex;
    if (DrawX == 10'd0) begin
      col_next = '0;
      ex_next  = '0;
    end else if (DrawX == prev_x + 10'd1) begin
      if (ex_sum >= SCREEN_W_A) begin
        ex_next  = ex_sum - SCREEN_W_A;
        col_next = col + ADDR_W'(1);
      end else begin
        ex_next = ex_sum;
      end
    end
  end

  // Row DDA: same stepping on Y, tracking row*IMG_W instead of the row number.
  always_comb begin
    ey_sum        = ey + IMG_H_A;
    row_base_next = row_base;
    ey_next       = ey;
    if (DrawY == 10'd0) begin
      row_base_next = '0;
      ey_next       = '0;
    end else if (DrawY == prev_y + 10'd1) begin
      if (ey_sum >= SCREEN_H_A) begin
        ey_next       = ey_sum - SCREEN_H_A;
        row_base_next = row_base + IMG_W_ADDR;
      end else begin
        ey_next = ey_sum;
      end
    end
  end

  assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'd0) && !prev_zero;
  assign pal_index  = rom_q;
  assign fade_busy  = (state != IDLE);

  // Fade next-state: level moves only on frame ticks; ends when the bound is held.
  always_comb begin
    state_next = state;
    cnt_next   = frame_cnt;
    level_next = level;
    done_next  = 1'b0;
    cnt_inc    = frame_cnt + CNT_W'(1);
    bound      = (state == FADE_IN) ? FULL : '0;
    level_step = (state == FADE_IN) ? level + 1'b1 : level - 1'b1;
    case (state)
      IDLE: begin
        if (fade_start) begin
          state_next = fade_dir ? FADE_IN : FADE_OUT;
          cnt_next   = '0;
        end
      end
      FADE_IN, FADE_OUT: begin
        if (frame_tick) begin
          if (level == bound) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (cnt_inc == FPS_C) begin
            cnt_next   = '0;
            level_next = level_step;
            if (level_step == bound) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stepper state, registered ROM address and blank pipeline.
  always_ff @(posedge vga_clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (reset) begin
      prev_x    <= '0;
      prev_y    <= '0;
      ex        <= '0;
      ey        <= '0;
      col       <= '0;
      row_base  <= '0;
      rom_addr  <= '0;
      blank_d1  <= 1'b0;
      blank_d2  <= 1'b0;
      prev_zero <= 1'b0;
    end else begin
      prev_x    <= DrawX;
      prev_y    <= DrawY;
      ex        <= ex_next;
      ey        <= ey_next;
      col       <= col_next;
      row_base  <= row_base_next;
      rom_addr  <= row_base_next + col_next;
      blank_d1  <= blank;
      blank_d2  <= blank_d1;
      prev_zero <= (DrawX == 10'd0) && (DrawY == 10'd0);
    end
  end

  // Fade state register; reset lands on full brightness with no done pulse.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state     <= IDLE;
      frame_cnt <= '0;
      level     <= FULL;
      fade_done <= 1'b0;
    end else begin
      state     <= state_next;
      frame_cnt <= cnt_next;
      level     <= level_next;
      fade_done <= done_next;
    end
  end

  // Output stage: scale the palette colour by level, black outside display.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (blank_d2) begin
      red   <= scale(pal_red, level);
      green <= scale(pal_green, level);
      blue  <= scale(pal_blue, level);
    end else begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end
  end

endmodule
